sdram_line_cache: RTL and testbench
===================================

# sdram_line_cache

Direct-mapped read cache and request sequencer that sits directly upstream of the SDRAM controller's main (`sel`/`rd`/`wr`) port. It serves 16-bit client reads from locally held 4-word lines. Misses are filled with one four-word burst read. Client writes go write-through as single-word SDRAM writes, and the cached copy is updated on a hit.

## Interface
Parameters:
- `LINES`, 64: number of cache lines; power of 2, minimum 2. `IW = log2(LINES)`.

Ports:
- `clk`  in  1  system clock; same clock as the SDRAM controller.
- `nRESET`  in  1  reset, synchronous, active-low (one clock; synchronous, active-low).
- `req`  in  1  client request, level; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  25  client word address [25:1].
- `bs`  in  2  write byte strobes: bit1 = high byte, bit0 = low byte.
- `wdata`  in  16  client write data.
- `rdata`  out  16  read data; valid while `ack`=1.
- `ack`  out  1  one-cycle completion pulse.
- `flush`  in  1  invalidate all lines.
- `sd_sel`  out  1  controller select; 1 while `sd_rd` or `sd_wr` is 1.
- `sd_addr`  out  25  controller address [25:1].
- `sd_rd`  out  1  controller read request.
- `sd_wr`  out  1  controller write request.
- `sd_burst`  out  1  1 with `sd_rd` (four-word burst), 0 otherwise.
- `sd_bs`  out  2  write byte strobes.
- `sd_din`  out  16  write data.
- `sd_ready`  in  1  controller ready/idle flag.
- `sd_dout`  in  64  burst data; the word at line offset k is at bits [63-16k : 48-16k].

## Operation
Address split:
- offset = `addr[2:1]`
- index = `addr[IW+2:3]`
- tag = `addr[25:IW+3]`

Storage per line: 64-bit data, tag, and a valid bit. Valid bits are flops and are cleared in a single cycle.

States:
- **SYNC**
  - Entered from reset.
  - Waits for `sd_ready`=1, then goes to IDLE.
  - Purpose: never misread a transaction the controller left in flight.
- **IDLE**, when `req`=1:
  - Read hit: `rdata` = line word and `ack`=1 on the next cycle; go to DONE.
  - Read miss: drive `sd_rd`=`sd_burst`=`sd_sel`=1 and `sd_addr`={`addr[25:3]`,2'b00}; go to RQ.
  - Write, `bs`≠0: drive `sd_wr`=`sd_sel`=1 with `sd_addr`=`addr`, `sd_bs`=`bs`, `sd_din`=`wdata`; go to RQ.
  - Write, `bs`=0: no SDRAM access; `ack` on the next cycle; go to DONE.
- **RQ**
  - Hold the request outputs until `sd_ready`=0 is sampled.
  - Then deassert `sd_rd`, `sd_wr`, `sd_sel` and `sd_burst`; go to WT.
- **WT**: on the first sampled `sd_ready`=1:
  - Read: write `sd_dout` into the line, set tag, set valid unless `flush` occurred during RQ/WT. Drive `rdata` = word at the requested offset, `ack`=1.
  - Write: if the line hits, merge `wdata` per `bs` into the cached word. `ack`=1.
  - Go to DONE.
- **DONE**
  - `ack` is high this cycle.
  - `req` is ignored this cycle.
  - Next state is IDLE.

Flush:
- `flush`=1 clears all valid bits on that edge, in any state.
- A flush in the same cycle as an IDLE lookup forces a miss.
- A fill in flight when `flush` rises delivers its data to the client but leaves the line invalid.

Client sequencing: the client holds `we`, `addr`, `bs` and `wdata` stable from `req` rising until `ack`. `req` may stay high across back-to-back transactions.

## Timing
- **Reset values**: `ack`=0, `rdata`=0, all `sd_*` outputs = 0, all valid bits = 0, state = SYNC.
- **Reset mid-operation**: request outputs drop on the reset edge. Any pending fill is discarded. The block goes to SYNC and waits for the controller to return to ready.
- **Read hit**: `req` sampled at edge N gives `ack` at cycle N+1. Throughput is one access per 2 cycles.
- **Miss or write latency**: 1 cycle for the request to appear, plus the controller's accept and transfer time, plus 1 cycle from `sd_ready` rising to `ack`.
- **Controller handshake**:
  - The controller registers `sd_ready`=0 one cycle after it accepts, and may delay acceptance for refresh.
  - RQ therefore waits indefinitely.
  - `sd_ready` rising marks `sd_dout` fully valid.
- **Simultaneous events**:
  - A write hit and `flush` in the same WT cycle: flush wins and the line ends invalid.
  - Two requests mapping to the same index: the second fill overwrites the first line.
- **Widths**: tag width = 23−IW. No arithmetic beyond the offset mux.

## Test plan
- **Reset values**: hold `nRESET`=0 with `sd_ready`=0, then release → all outputs 0 and no `sd_rd` until `sd_ready`=1; `ack` stays 0.
- **Miss then hit**:
  - Read `addr`=0x000105 → `sd_rd`=1, `sd_burst`=1, `sd_addr`=0x000104.
  - Model returns `sd_dout`=0x1111_2222_3333_4444 → `rdata`=0x2222 with `ack`.
  - Read 0x000107 → `ack` one cycle later with `rdata`=0x4444 and no `sd_rd`.
- **Write-through merge**: write 0x000104, `bs`=2'b01, `wdata`=0xABCD on the cached line → `sd_wr`=1, `sd_bs`=01. A later read of 0x000104 hits with `rdata`=0x11CD.
- **Conflict**: with LINES=64, read 0x000104, then 0x000304 (same index, different tag) → two bursts. A re-read of 0x000104 misses again.
- **Flush**: `flush` pulsed while in WT of a fill → `ack` with the correct data, but an immediate re-read of the same address misses.
- **Zero strobes and delayed accept**:
  - Write with `bs`=0 → `ack` next cycle and no `sd_wr`.
  - Model holds `sd_ready`=1 for 20 cycles after `sd_rd` → `sd_rd` stays asserted throughout, with no spurious `ack`.

Source files
------------

// File: rtl/sdram_line_cache.sv
// Direct-mapped read cache with write-through, sequencing requests onto the SDRAM controller main port.
// Latency: read hit acks one cycle after req is sampled; misses/writes add controller accept and transfer time plus one cycle.
// Backpressure: the controller request is held until sd_ready drops, then the block waits for sd_ready to return.
module sdram_line_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        req,
  input  logic        we,
  input  logic [25:1] addr,
  input  logic [1:0]  bs,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  input  logic        flush,
  output logic        sd_sel,
  output logic [25:1] sd_addr,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        sd_burst,
  output logic [1:0]  sd_bs,
  output logic [15:0] sd_din,
  input  logic        sd_ready,
  input  logic [63:0] sd_dout
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 23 - IW;

  typedef enum logic [2:0] {SYNC, IDLE, RQ, WT, DONE} state_t;

  state_t state, state_nxt;

  logic [63:0]      line_dat [LINES];
  logic [TW-1:0]    line_tag [LINES];
  logic [LINES-1:0] line_vld;
  logic             flush_seen;

  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          tag_hit;
  logic [15:0]   cur_word;
  logic [15:0]   merged_word;

  logic          ack_nxt, sd_sel_nxt, sd_rd_nxt, sd_wr_nxt, sd_burst_nxt;
  logic [15:0]   rdata_nxt, sd_din_nxt;
  logic [25:1]   sd_addr_nxt;
  logic [1:0]    sd_bs_nxt;
  logic          fill_en, merge_en;

  // Word k of a line sits in the most-significant-first slot k.
  function automatic logic [15:0] word_of(input logic [63:0] l, input logic [1:0] k);
    logic [15:0] w;
    case (k)
      2'd0:    w = l[63:48];
      2'd1:    w = l[47:32];
      2'd2:    w = l[31:16];
      default: w = l[15:0];
    endcase
    return w;
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] l, input logic [1:0] k,
                                           input logic [15:0] w);
    logic [63:0] r;
    r = l;
    case (k)
      2'd0:    r[63:48] = w;
      2'd1:    r[47:32] = w;
      2'd2:    r[31:16] = w;
      default: r[15:0]  = w;
    endcase
    return r;
  endfunction

  assign off         = addr[2:1];
  assign idx         = addr[IW+2:3];
  assign tag         = addr[25:IW+3];
  assign tag_hit     = line_vld[idx] && (line_tag[idx] == tag);
  assign cur_word    = word_of(line_dat[idx], off);
  assign merged_word = {bs[1] ? wdata[15:8] : cur_word[15:8],
                        bs[0] ? wdata[7:0]  : cur_word[7:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!nRESET) state <= SYNC;
    else         state <= state_nxt;
  end

  // Next state, next registered outputs and line update strobes.
  always_comb begin
    state_nxt    = state;
    ack_nxt      = 1'b0;
    rdata_nxt    = rdata;
    sd_sel_nxt   = sd_sel;
    sd_rd_nxt    = sd_rd;
    sd_wr_nxt    = sd_wr;
    sd_burst_nxt = sd_burst;
    sd_addr_nxt  = sd_addr;
    sd_bs_nxt    = sd_bs;
    sd_din_nxt   = sd_din;
    fill_en      = 1'b0;
    merge_en     = 1'b0;
    case (state)
      SYNC: if (sd_ready) state_nxt = IDLE;
      IDLE: begin
        if (req) begin
          if (!we) begin
            // A flush on the lookup edge wipes the line, so it cannot hit.
            if (tag_hit && !flush) begin
              ack_nxt   = 1'b1;
              rdata_nxt = cur_word;
              state_nxt = DONE;
            end else begin
              sd_sel_nxt   = 1'b1;
              sd_rd_nxt    = 1'b1;
              sd_burst_nxt = 1'b1;
              sd_addr_nxt  = {addr[25:3], 2'b00};
              sd_bs_nxt    = 2'b00;
              sd_din_nxt   = 16'h0000;
              state_nxt    = RQ;
            end
          end else if (bs != 2'b00) begin
            sd_sel_nxt  = 1'b1;
            sd_wr_nxt   = 1'b1;
            sd_addr_nxt = addr;
            sd_bs_nxt   = bs;
            sd_din_nxt  = wdata;
            state_nxt   = RQ;
          end else begin
            ack_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      RQ: begin
        if (!sd_ready) begin
          sd_sel_nxt   = 1'b0;
          sd_rd_nxt    = 1'b0;
          sd_wr_nxt    = 1'b0;
          sd_burst_nxt = 1'b0;
          state_nxt    = WT;
        end
      end
      WT: begin
        if (sd_ready) begin
          ack_nxt = 1'b1;
          if (!we) begin
            fill_en   = 1'b1;
            rdata_nxt = word_of(sd_dout, off);
          end else begin
            merge_en = tag_hit;
          end
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  // Registered client and controller outputs.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      ack      <= 1'b0;
      rdata    <= 16'h0000;
      sd_sel   <= 1'b0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      sd_burst <= 1'b0;
      sd_addr  <= '0;
      sd_bs    <= 2'b00;
      sd_din   <= 16'h0000;
    end else begin
      ack      <= ack_nxt;
      rdata    <= rdata_nxt;
      sd_sel   <= sd_sel_nxt;
      sd_rd    <= sd_rd_nxt;
      sd_wr    <= sd_wr_nxt;
      sd_burst <= sd_burst_nxt;
      sd_addr  <= sd_addr_nxt;
      sd_bs    <= sd_bs_nxt;
      sd_din   <= sd_din_nxt;
    end
  end

  // Valid bits: a flush anywhere in a fill leaves that line invalid; a flush edge always wins.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      line_vld   <= '0;
      flush_seen <= 1'b0;
    end else begin
      if (state == IDLE) flush_seen <= 1'b0;
      else if (flush)    flush_seen <= 1'b1;
      if (fill_en) line_vld[idx] <= !flush_seen;
      if (flush)   line_vld      <= '0;
    end
  end

  // Line data and tags; not reset since valid bits gate their use.
  always_ff @(posedge clk) begin
    if (nRESET && fill_en) begin
      line_dat[idx] <= sd_dout;
      line_tag[idx] <= tag;
    end else if (nRESET && merge_en) begin
      line_dat[idx] <= put_word(line_dat[idx], off, merged_word);
    end
  end

endmodule

// File: tb/tb_sdram_line_cache.sv
// Bench for sdram_line_cache: SDRAM controller model, directed vector table, reset corners and random traffic.
// Expected data comes from a word-level memory model; hit/miss from a tag-per-index residency model.
// The controller model can delay acceptance and stretch the transfer to exercise the request hold.
module tb_sdram_line_cache;
  localparam int L = 64;

  logic        clk = 1'b0;
  logic        nRESET, req, we, flush;
  logic [25:1] addr;
  logic [1:0]  bs;
  logic [15:0] wdata, rdata, sd_din;
  logic        ack, sd_sel, sd_rd, sd_wr, sd_burst, sd_ready;
  logic [25:1] sd_addr;
  logic [1:0]  sd_bs;
  logic [63:0] sd_dout;

  always #5 clk = ~clk;

  sdram_line_cache #(.LINES(L)) dut (
    .clk(clk), .nRESET(nRESET), .req(req), .we(we), .addr(addr), .bs(bs), .wdata(wdata),
    .rdata(rdata), .ack(ack), .flush(flush), .sd_sel(sd_sel), .sd_addr(sd_addr),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_burst(sd_burst), .sd_bs(sd_bs), .sd_din(sd_din),
    .sd_ready(sd_ready), .sd_dout(sd_dout)
  );

  int checks = 0, errors = 0, perr_m = 0, perr_c = 0;
  logic        m_en = 1'b0, m_active = 1'b0, m_is_rd = 1'b0, m_last_burst = 1'b0;
  int          acc_dly = 0, busy_len = 2, m_cnt = 0, m_wait = 0, m_rd_cnt = 0, m_wr_cnt = 0;
  logic [25:1] m_last_addr = '0;
  logic        tb_busy = 1'b0;
  logic [15:0] mem [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] mem_init(input int a);
    logic [31:0] v;
    v = a;
    return v[15:0] ^ {v[23:16], v[7:0]} ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return mem_init(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_init(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
    return {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
  endfunction

  // Controller model: accepts after acc_dly cycles of a held request, busy for busy_len cycles.
  always @(negedge clk) begin : model
    int a;
    if (!m_en) begin
      sd_ready = 1'b0; sd_dout = '0; m_active = 1'b0; m_wait = 0;
    end else if (m_active) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        m_active = 1'b0;
        sd_ready = 1'b1;
        if (m_is_rd) begin
          a = int'(m_last_addr);
          sd_dout = {mem_rd(a), mem_rd(a + 1), mem_rd(a + 2), mem_rd(a + 3)};
        end
      end
    end else begin
      sd_ready = 1'b1;
      if (sd_rd || sd_wr) begin
        if (m_wait >= acc_dly) begin
          a = int'(sd_addr);
          m_last_addr = sd_addr; m_last_burst = sd_burst; m_is_rd = sd_rd;
          if (sd_rd) m_rd_cnt++;
          else begin
            m_wr_cnt++;
            mem[a] = merge(mem_rd(a), sd_din, sd_bs);
          end
          m_wait = 0; m_active = 1'b1; m_cnt = busy_len; sd_ready = 1'b0;
        end else m_wait++;
      end else begin
        if (m_wait != 0) perr_m++;
        m_wait = 0;
      end
    end
  end

  // Protocol monitor: select/burst consistency and no acks outside a transaction.
  always @(negedge clk) begin
    if (nRESET) begin
      if (sd_sel !== (sd_rd | sd_wr)) perr_c++;
      if (sd_burst !== sd_rd) perr_c++;
      if (ack && !tb_busy) perr_c++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input logic w, input int a, input logic [1:0] b, input logic [15:0] d,
                        input int fl_cyc, output logic [15:0] rd, output int lat,
                        output int nrd, output int nwr);
    int rd0, wr0;
    rd0 = m_rd_cnt; wr0 = m_wr_cnt;
    tb_busy = 1'b1;
    we = w; addr = 25'(a); bs = b; wdata = d; req = 1'b1;
    lat = 0; rd = 16'h0000;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      flush = 1'b0;
      if (ack) begin lat = c; rd = rdata; break; end
      if (c == fl_cyc) flush = 1'b1;
    end
    req = 1'b0; flush = 1'b0;
    nrd = m_rd_cnt - rd0; nwr = m_wr_cnt - wr0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL timeout: no ack for addr %0h", a);
    end
    @(negedge clk);
    tb_busy = 1'b0;
  endtask

  typedef struct {
    logic w; int a; logic [1:0] b; logic [15:0] d;
    logic fpre; int flc; int acc; int busy;
    logic [15:0] er; int erd; int ewr; int elat;
  } vec_t;

  vec_t tv [21];
  logic cv [L];
  int   ct [L];

  initial begin
    logic [15:0] r;
    int lat, nrd, nwr, seen, a, ix, tg, erd, ewr, elat;
    logic w, fp, hit;
    logic [1:0] b;
    logic [15:0] d, er;

    // w, addr, bs, wdata, flush_pre, flush_cyc, accept delay, busy, exp rdata, bursts, writes, latency
    tv[0]  = '{1'b0, 'h105, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h2222, 1, 0, 4};
    tv[1]  = '{1'b0, 'h107, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h4444, 0, 0, 1};
    tv[2]  = '{1'b1, 'h104, 2'b01, 16'hABCD, 1'b0, 0, 0, 2, 16'h0000, 0, 1, 4};
    tv[3]  = '{1'b0, 'h104, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h11CD, 0, 0, 1};
    tv[4]  = '{1'b1, 'h106, 2'b00, 16'hFFFF, 1'b0, 0, 0, 2, 16'h0000, 0, 0, 1};
    tv[5]  = '{1'b0, 'h106, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h3333, 0, 0, 1};
    tv[6]  = '{1'b0, 'h304, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h9A01, 1, 0, 4};
    tv[7]  = '{1'b0, 'h104, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h11CD, 1, 0, 4};
    tv[8]  = '{1'b1, 'h105, 2'b10, 16'hBEEF, 1'b0, 0, 0, 2, 16'h0000, 0, 1, 4};
    tv[9]  = '{1'b0, 'h105, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'hBE22, 0, 0, 1};
    tv[10] = '{1'b1, 'h500, 2'b11, 16'h1234, 1'b0, 0, 0, 2, 16'h0000, 0, 1, 4};
    tv[11] = '{1'b0, 'h500, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h1234, 1, 0, 4};
    tv[12] = '{1'b0, 'h500, 2'b00, 16'h0000, 1'b1, 0, 0, 2, 16'h1234, 1, 0, 4};
    tv[13] = '{1'b0, 'h708, 2'b00, 16'h0000, 1'b0, 3, 0, 5, mem_init('h708), 1, 0, 7};
    tv[14] = '{1'b0, 'h708, 2'b00, 16'h0000, 1'b0, 0, 0, 2, mem_init('h708), 1, 0, 4};
    tv[15] = '{1'b0, 'h70B, 2'b00, 16'h0000, 1'b0, 0, 0, 2, mem_init('h70B), 0, 0, 1};
    tv[16] = '{1'b1, 'h70B, 2'b11, 16'h5555, 1'b0, 2, 0, 2, 16'h0000, 0, 1, 4};
    tv[17] = '{1'b0, 'h70B, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h5555, 1, 0, 4};
    tv[18] = '{1'b0, 'h90C, 2'b00, 16'h0000, 1'b0, 0, 20, 2, mem_init('h90C), 1, 0, 24};
    tv[19] = '{1'b1, 'h90C, 2'b11, 16'h7777, 1'b0, 0, 20, 2, 16'h0000, 0, 1, 24};
    tv[20] = '{1'b0, 'h90C, 2'b00, 16'h0000, 1'b0, 0, 0, 2, 16'h7777, 0, 0, 1};

    mem['h104] = 16'h1111; mem['h105] = 16'h2222; mem['h106] = 16'h3333; mem['h107] = 16'h4444;
    mem['h304] = 16'h9A01;

    nRESET = 1'b0; req = 1'b0; we = 1'b0; addr = '0; bs = 2'b00; wdata = 16'h0000; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {ack, rdata, sd_sel, sd_addr, sd_rd, sd_wr, sd_burst, sd_bs, sd_din}, 64'h0);

    // Controller still busy after reset: a request must not be issued.
    nRESET = 1'b1; req = 1'b1; we = 1'b0; addr = 25'h105;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (sd_rd || sd_sel || sd_wr || ack || rdata != 16'h0000) seen = 1;
    end
    chk("sync holds off", 64'(seen), 64'h0);
    req = 1'b0; m_en = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      acc_dly = tv[i].acc; busy_len = tv[i].busy;
      if (tv[i].fpre) begin flush = 1'b1; @(negedge clk); flush = 1'b0; end
      do_txn(tv[i].w, tv[i].a, tv[i].b, tv[i].d, tv[i].flc, r, lat, nrd, nwr);
      if (!tv[i].w) chk($sformatf("v%0d rdata", i), 64'(r), 64'(tv[i].er));
      chk($sformatf("v%0d bursts", i), 64'(nrd), 64'(tv[i].erd));
      chk($sformatf("v%0d writes", i), 64'(nwr), 64'(tv[i].ewr));
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(tv[i].elat));
      if (i == 0) begin
        chk("v0 sd_addr", 64'(m_last_addr), 64'h104);
        chk("v0 sd_burst", 64'(m_last_burst), 64'h1);
      end
    end

    // Reset during a fill: request drops, fill is discarded, cache comes back empty.
    busy_len = 6; acc_dly = 0;
    req = 1'b1; we = 1'b0; addr = 25'hA00;
    repeat (3) @(negedge clk);
    nRESET = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("mid-op reset outputs", {60'h0, sd_sel, sd_rd, sd_wr, ack}, 64'h0);
    nRESET = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!m_active && sd_ready) break;
    end
    chk("controller idle again", 64'(sd_ready), 64'h1);
    @(negedge clk);
    busy_len = 2;
    do_txn(1'b0, 'hA00, 2'b00, 16'h0, 0, r, lat, nrd, nwr);
    chk("post-reset A00 rdata", 64'(r), 64'(mem_init('hA00)));
    chk("post-reset A00 bursts", 64'(nrd), 64'h1);
    do_txn(1'b0, 'h90C, 2'b00, 16'h0, 0, r, lat, nrd, nwr);
    chk("post-reset 90C rdata", 64'(r), 64'h7777);
    chk("post-reset 90C bursts", 64'(nrd), 64'h1);

    // Random traffic against the word-level memory and residency model.
    for (int k = 0; k < L; k++) begin cv[k] = 1'b0; ct[k] = 0; end
    for (int n = 0; n < 200; n++) begin
      w  = ($urandom_range(0, 2) == 0);
      a  = 'h10000 + int'($urandom_range(0, 3)) * 256 + int'($urandom_range(0, 47));
      b  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      fp = ($urandom_range(0, 15) == 0);
      acc_dly = int'($urandom_range(0, 3)); busy_len = int'($urandom_range(1, 4));
      ix = (a / 4) % L; tg = a / (4 * L);
      if (fp) begin
        for (int k = 0; k < L; k++) cv[k] = 1'b0;
        flush = 1'b1; @(negedge clk); flush = 1'b0;
      end
      er = 16'h0000;
      if (!w) begin
        hit  = cv[ix] && (ct[ix] == tg);
        er   = ref_rd(a);
        erd  = hit ? 0 : 1;
        ewr  = 0;
        elat = hit ? 1 : 2 + busy_len + acc_dly;
        cv[ix] = 1'b1; ct[ix] = tg;
      end else begin
        erd  = 0;
        ewr  = (b != 2'b00) ? 1 : 0;
        elat = (b != 2'b00) ? 2 + busy_len + acc_dly : 1;
        if (b != 2'b00) ref_mem[a] = merge(ref_rd(a), d, b);
      end
      do_txn(w, a, b, d, 0, r, lat, nrd, nwr);
      if (!w) chk($sformatf("rnd%0d rdata @%0h", n, a), 64'(r), 64'(er));
      chk($sformatf("rnd%0d bursts @%0h", n, a), 64'(nrd), 64'(erd));
      chk($sformatf("rnd%0d writes @%0h", n, a), 64'(nwr), 64'(ewr));
      chk($sformatf("rnd%0d latency @%0h", n, a), 64'(lat), 64'(elat));
    end

    chk("protocol violations", 64'(perr_m + perr_c), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
